// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by the interface, the adder cell and the sequencer.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Wide enough to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
// The requester drives through master, the adder through slave.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] augend;
    logic [WIDTH-1:0] addend;
    logic             carry_in;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             done;

    modport master (
        output start,
        output augend,
        output addend,
        output carry_in,
        input  ready,
        input  busy,
        input  sum,
        input  carry_out,
        input  overflow,
        input  done
    );

    modport slave (
        input  start,
        input  augend,
        input  addend,
        input  carry_in,
        output ready,
        output busy,
        output sum,
        output carry_out,
        output overflow,
        output done
    );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full-adder cell driven by the serial adder sequencer.
// Purely combinational.
module full_adder_bit
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic half;

    assign half      = a ^ b;
    assign sum       = half ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first,
// through a single full-adder cell, with carry-out and overflow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic           clock,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last_bit;

    full_adder_bit u_fa (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (state == SHIFT) && (cnt_q == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.augend;
            b_q     <= bus.addend;
            carry_q <= bus.carry_in;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else if (state == SHIFT) begin
            // Result enters at the MSB so bit 0 lands last at bit 0.
            sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_carry;
            cnt_q   <= cnt_q + 1'b1;
            if (last_bit) begin
                // carry_q here is the carry into the MSB.
                ovf_q  <= carry_q ^ fa_carry;
                cout_q <= fa_carry;
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule
